// File: rtl/sevga_vram_arbiter_if.sv
// SE-VGA VRAM arbiter bus bundle: video fetch, CPU write push and VRAM pins.
// slave = arbiter side, master = surrounding adapter logic.
interface sevga_vram_arbiter_if #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int NUM_BUFS = 2,
  parameter int BUF_W    = $clog2(NUM_BUFS),
  parameter int SEQ_W    = 3
);
  logic [SEQ_W-1:0]    seq;
  logic                vidReq;
  logic [ADDR_W-1:0]   vidAddr;
  logic [BUF_W-1:0]    vidBufSel;
  logic [DATA_W-1:0]   vidData;
  logic                vidValid;
  logic                cpuWrReq;
  logic [ADDR_W-1:0]   cpuWrAddr;
  logic [DATA_W-1:0]   cpuWrData;
  logic [BUF_W-1:0]    cpuWrBuf;
  logic                cpuWrFull;
  logic [ADDR_W-1:0]   vramAddr;
  logic [DATA_W-1:0]   vramDataOut;
  logic                vramDataOe;
  logic [DATA_W-1:0]   vramDataIn;
  logic                nvramOE;
  logic                nvramWE;
  logic [NUM_BUFS-1:0] nvramCE;
  logic [7:0]          dropCount;

  modport slave (
    input  seq,
    input  vidReq,
    input  vidAddr,
    input  vidBufSel,
    output vidData,
    output vidValid,
    input  cpuWrReq,
    input  cpuWrAddr,
    input  cpuWrData,
    input  cpuWrBuf,
    output cpuWrFull,
    output vramAddr,
    output vramDataOut,
    output vramDataOe,
    input  vramDataIn,
    output nvramOE,
    output nvramWE,
    output nvramCE,
    output dropCount
  );

  modport master (
    output seq,
    output vidReq,
    output vidAddr,
    output vidBufSel,
    input  vidData,
    input  vidValid,
    output cpuWrReq,
    output cpuWrAddr,
    output cpuWrData,
    output cpuWrBuf,
    input  cpuWrFull,
    input  vramAddr,
    input  vramDataOut,
    input  vramDataOe,
    output vramDataIn,
    input  nvramOE,
    input  nvramWE,
    input  nvramCE,
    input  dropCount
  );
endinterface

// File: rtl/sevga_vram_arbiter.sv
// SE-VGA VRAM arbiter: posted CPU writes, one guaranteed video slot per seq.
// Define SEVGA_WRDROP_CNT_EN to build the saturating dropped-write counter.
module sevga_vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_BUFS   = 2,
  parameter int BUF_W      = $clog2(NUM_BUFS),
  parameter int SEQ_W      = 3,
  parameter int VID_SLOT   = 0
) (
  input logic                 pixClk,
  input logic                 nReset,
  sevga_vram_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] L_DEPTH =
    CNT_W'(FIFO_DEPTH);
  localparam logic [SEQ_W-1:0] L_SLOT =
    SEQ_W'(VID_SLOT);
  localparam logic [SEQ_W-1:0] L_BLK1 =
    L_SLOT - SEQ_W'(1);
  localparam logic [SEQ_W-1:0] L_BLK2 =
    L_SLOT - SEQ_W'(2);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RD        = 2'd1;
  localparam logic [1:0] S_WR_SETUP  = 2'd2;
  localparam logic [1:0] S_WR_STROBE = 2'd3;

  logic [1:0]          r_state;

  logic [ADDR_W-1:0]   r_fAddr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fData [FIFO_DEPTH];
  logic [BUF_W-1:0]    r_fBuf  [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [CNT_W-1:0]    r_cnt;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_dout;
  logic                r_dataOe;
  logic                r_nOE;
  logic                r_nWE;
  logic [NUM_BUFS-1:0] r_nCE;
  logic [DATA_W-1:0]   r_vidData;
  logic                r_vidValid;

  logic                w_rdGo;
  logic                w_blk;
  logic                w_pop;
  logic                w_push;
  logic [ADDR_W-1:0]   w_hAddr;
  logic [DATA_W-1:0]   w_hData;
  logic [BUF_W-1:0]    w_hBuf;

  // Out-of-range buffer index selects nothing but still uses the slot.
  function automatic logic [NUM_BUFS-1:0] ce_mask(
    input logic [BUF_W-1:0] b
  );
    logic [NUM_BUFS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_BUFS; i++) begin
      if (b == BUF_W'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  // A write may only start where it finishes before the video slot edge.
  always_comb begin
    w_rdGo = (r_state == S_IDLE)
          && (bus.seq == L_SLOT)
          && bus.vidReq;
    w_blk  = (bus.seq == L_BLK1)
          || (bus.seq == L_BLK2);
    w_pop  = (r_state == S_IDLE)
          && !w_rdGo
          && !w_blk
          && (r_cnt != '0);
    w_push = bus.cpuWrReq
          && ((r_cnt != L_DEPTH) || w_pop);
  end

  assign w_hAddr = r_fAddr[r_rdPtr];
  assign w_hData = r_fData[r_rdPtr];
  assign w_hBuf  = r_fBuf[r_rdPtr];

  always_ff @(posedge pixClk) begin
    if (w_push) begin
      r_fAddr[r_wrPtr] <= bus.cpuWrAddr;
      r_fData[r_wrPtr] <= bus.cpuWrData;
      r_fBuf[r_wrPtr]  <= bus.cpuWrBuf;
    end
  end

  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + CNT_W'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_dout     <= '0;
      r_dataOe   <= 1'b0;
      r_nOE      <= 1'b1;
      r_nWE      <= 1'b1;
      r_nCE      <= '1;
      r_vidData  <= '0;
      r_vidValid <= 1'b0;
    end else begin
      r_vidValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rdGo) begin
            r_state <= S_RD;
            r_addr  <= bus.vidAddr;
            r_nOE   <= 1'b0;
            r_nCE   <= ce_mask(bus.vidBufSel);
          end else if (w_pop) begin
            r_state  <= S_WR_SETUP;
            r_addr   <= w_hAddr;
            r_dout   <= w_hData;
            r_dataOe <= 1'b1;
            r_nCE    <= ce_mask(w_hBuf);
          end
        end
        S_RD: begin
          r_state    <= S_IDLE;
          r_vidData  <= bus.vramDataIn;
          r_vidValid <= 1'b1;
          r_addr     <= '0;
          r_nOE      <= 1'b1;
          r_nCE      <= '1;
        end
        S_WR_SETUP: begin
          r_state <= S_WR_STROBE;
          r_nWE   <= 1'b0;
        end
        S_WR_STROBE: begin
          r_state  <= S_IDLE;
          r_nWE    <= 1'b1;
          r_addr   <= '0;
          r_dout   <= '0;
          r_dataOe <= 1'b0;
          r_nCE    <= '1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEVGA_WRDROP_CNT_EN
  logic [7:0] r_drop;
  logic       w_reject;

  assign w_reject = bus.cpuWrReq && !w_push;

  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset)
      r_drop <= 8'd0;
    else if (w_reject && (r_drop != 8'hFF))
      r_drop <= r_drop + 8'd1;
  end

  assign bus.dropCount = r_drop;
`else
  assign bus.dropCount = 8'd0;
`endif

  assign bus.cpuWrFull   = (r_cnt == L_DEPTH);
  assign bus.vramAddr    = r_addr;
  assign bus.vramDataOut = r_dout;
  assign bus.vramDataOe  = r_dataOe;
  assign bus.nvramOE     = r_nOE;
  assign bus.nvramWE     = r_nWE;
  assign bus.nvramCE     = r_nCE;
  assign bus.vidData     = r_vidData;
  assign bus.vidValid    = r_vidValid;

endmodule

// File: tb/tb_sevga_vram_arbiter.sv
// Directed bench for sevga_vram_arbiter: reads, posted writes, full FIFO, reset.
// Expected timings are hand-derived from an 8-cycle sequence with slot 0.
module tb_sevga_vram_arbiter;

`ifdef SEVGA_WRDROP_CNT_EN
  localparam logic [7:0] DROP2 = 8'd2;
`else
  localparam logic [7:0] DROP2 = 8'd0;
`endif

  logic pixClk = 1'b0;
  logic nReset = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  sevga_vram_arbiter_if #(
    .ADDR_W(15), .DATA_W(8), .NUM_BUFS(2),
    .BUF_W(1), .SEQ_W(3)
  ) bus ();

  sevga_vram_arbiter #(
    .ADDR_W(15), .DATA_W(8), .FIFO_DEPTH(4),
    .NUM_BUFS(2), .BUF_W(1), .SEQ_W(3), .VID_SLOT(0)
  ) dut (
    .pixClk(pixClk),
    .nReset(nReset),
    .bus(bus)
  );

  always #5 pixClk = ~pixClk;

  task automatic step();
    @(posedge pixClk);
    #1;
    bus.seq = bus.seq + 3'd1;
  endtask

  task automatic push(input logic [14:0] a,
                      input logic [7:0] d,
                      input logic b);
    bus.cpuWrReq  = 1'b1;
    bus.cpuWrAddr = a;
    bus.cpuWrData = d;
    bus.cpuWrBuf  = b;
  endtask

  task automatic test_reset();
    nReset         = 1'b0;
    bus.seq        = 3'd0;
    bus.vidReq     = 1'b1;
    bus.vidAddr    = 15'h1234;
    bus.vidBufSel  = 1'b1;
    bus.vramDataIn = 8'hA5;
    bus.cpuWrReq   = 1'b0;
    bus.cpuWrAddr  = '0;
    bus.cpuWrData  = '0;
    bus.cpuWrBuf   = 1'b0;
    repeat (2) @(posedge pixClk);
    #1;
    total++;
    if ({bus.nvramOE, bus.nvramWE, bus.nvramCE, bus.vramDataOe} !== 5'b11110) begin
      bad++;
      $display("FAIL rst_strobes got=%b want=11110",
        {bus.nvramOE, bus.nvramWE, bus.nvramCE, bus.vramDataOe});
    end
    total++;
    if ({bus.vramAddr, bus.vramDataOut} !== 23'd0) begin
      bad++;
      $display("FAIL rst_addr_data got=%h/%h want=0/0", bus.vramAddr, bus.vramDataOut);
    end
    total++;
    if ({bus.vidValid, bus.vidData, bus.cpuWrFull, bus.dropCount} !== 18'd0) begin
      bad++;
      $display("FAIL rst_misc got=%b/%h/%b/%h want=0/0/0/0",
        bus.vidValid, bus.vidData, bus.cpuWrFull, bus.dropCount);
    end
  endtask

  task automatic test_read();
    int n;
    nReset = 1'b1;
    step();
    total++;
    if ({bus.nvramOE, bus.nvramCE, bus.nvramWE} !== 4'b0011) begin
      bad++;
      $display("FAIL rd_strobe got=%b want=0011", {bus.nvramOE, bus.nvramCE, bus.nvramWE});
    end
    total++;
    if (bus.vramAddr !== 15'h1234) begin
      bad++;
      $display("FAIL rd_addr got=%h want=1234", bus.vramAddr);
    end
    step();
    total++;
    if ({bus.vidValid, bus.vidData} !== 9'h1A5) begin
      bad++;
      $display("FAIL rd_data got=%b/%h want=1/a5", bus.vidValid, bus.vidData);
    end
    total++;
    if ({bus.nvramOE, bus.nvramCE, bus.vramAddr} !== 18'h38000) begin
      bad++;
      $display("FAIL rd_release got=%b/%b/%h want=1/11/0",
        bus.nvramOE, bus.nvramCE, bus.vramAddr);
    end
    step();
    total++;
    if (bus.vidValid !== 1'b0) begin
      bad++;
      $display("FAIL rd_pulse got=%b want=0", bus.vidValid);
    end
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.vidValid === 1'b1) n++;
    end
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL rd_rate got=%0d want=2", n);
    end
  endtask

  task automatic test_single_write();
    int n;
    push(15'h0100, 8'h3C, 1'b0);
    step();
    bus.cpuWrReq = 1'b0;
    total++;
    if ({bus.nvramWE, bus.vramDataOe, bus.cpuWrFull} !== 3'b100) begin
      bad++;
      $display("FAIL wr_early got=%b want=100", {bus.nvramWE, bus.vramDataOe, bus.cpuWrFull});
    end
    step();
    total++;
    if ({bus.nvramWE, bus.vramDataOe, bus.nvramCE} !== 4'b1110) begin
      bad++;
      $display("FAIL wr_setup got=%b want=1110", {bus.nvramWE, bus.vramDataOe, bus.nvramCE});
    end
    total++;
    if ({bus.vramAddr, bus.vramDataOut} !== {15'h0100, 8'h3C}) begin
      bad++;
      $display("FAIL wr_setup_ad got=%h/%h want=0100/3c", bus.vramAddr, bus.vramDataOut);
    end
    step();
    total++;
    if ({bus.nvramWE, bus.vramDataOe, bus.nvramCE, bus.vramAddr, bus.vramDataOut}
        !== {4'b0110, 15'h0100, 8'h3C}) begin
      bad++;
      $display("FAIL wr_strobe got=%b/%h/%h want=0110/0100/3c",
        {bus.nvramWE, bus.vramDataOe, bus.nvramCE}, bus.vramAddr, bus.vramDataOut);
    end
    step();
    total++;
    if ({bus.nvramWE, bus.vramDataOe, bus.nvramCE, bus.vramAddr} !== {4'b1011, 15'h0}) begin
      bad++;
      $display("FAIL wr_end got=%b/%h want=1011/0",
        {bus.nvramWE, bus.vramDataOe, bus.nvramCE}, bus.vramAddr);
    end
    n = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (bus.nvramWE === 1'b0) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL wr_empty got=%0d want=0", n);
    end
  endtask

  task automatic test_deferred();
    int vs, ws;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic [1:0]  wc;
    vs = 0; ws = 0; wa = '0; wd = '0; wc = '0;
    bus.vramDataIn = 8'h5B;
    push(15'h0222, 8'h5A, 1'b1);
    step();
    bus.cpuWrReq = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (bus.vidValid === 1'b1 && vs == 0) vs = k;
      if (bus.nvramWE === 1'b0 && ws == 0) begin
        ws = k;
        wa = bus.vramAddr;
        wd = bus.vramDataOut;
        wc = bus.nvramCE;
      end
    end
    total++;
    if (vs != 3 || ws != 5) begin
      bad++;
      $display("FAIL defer_order got=rd%0d/we%0d want=rd3/we5", vs, ws);
    end
    total++;
    if ({wa, wd, wc} !== {15'h0222, 8'h5A, 2'b01}) begin
      bad++;
      $display("FAIL defer_write got=%h/%h/%b want=0222/5a/01", wa, wd, wc);
    end
    total++;
    if (bus.vidData !== 8'h5B) begin
      bad++;
      $display("FAIL defer_rd got=%h want=5b", bus.vidData);
    end
  endtask

  task automatic test_back_to_back();
    int n, nv;
    int          ws [16];
    logic [14:0] wa [16];
    logic [7:0]  wd [16];
    logic [1:0]  wc [16];
    int          es [4];
    es = '{3, 6, 11, 14};
    repeat (5) step();
    push(15'h0300, 8'h11, 1'b0);
    step();
    for (int i = 0; i < 6; i++) begin
      push(15'h0400 + 15'(i), 8'h20 + 8'(i), 1'(i % 2));
      step();
      total++;
      if (bus.cpuWrFull !== (i >= 3)) begin
        bad++;
        $display("FAIL b2b_full%0d got=%b want=%b", i, bus.cpuWrFull, i >= 3);
      end
    end
    bus.cpuWrReq = 1'b0;
    total++;
    if (bus.dropCount !== DROP2) begin
      bad++;
      $display("FAIL b2b_drop got=%0d want=%0d", bus.dropCount, DROP2);
    end
    n = 0; nv = 0;
    for (int k = 0; k < 16; k++) begin
      ws[k] = 0; wa[k] = '0; wd[k] = '0; wc[k] = '0;
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      if (bus.vidValid === 1'b1) nv++;
      if (bus.nvramWE === 1'b0) begin
        ws[n] = k;
        wa[n] = bus.vramAddr;
        wd[n] = bus.vramDataOut;
        wc[n] = bus.nvramCE;
        n++;
      end
    end
    total++;
    if (n != 4 || nv != 2) begin
      bad++;
      $display("FAIL b2b_count got=we%0d/rd%0d want=we4/rd2", n, nv);
    end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (ws[j] != es[j] || wa[j] !== 15'h0400 + 15'(j)
          || wd[j] !== 8'h20 + 8'(j)
          || wc[j] !== ((j % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL b2b_wr%0d got=t%0d/%h/%h/%b want=t%0d/%h/%h",
          j, ws[j], wa[j], wd[j], wc[j], es[j], 15'h0400 + 15'(j), 8'h20 + 8'(j));
      end
    end
    total++;
    if (bus.cpuWrFull !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drained got=%b want=0", bus.cpuWrFull);
    end
  endtask

  task automatic test_full_pop();
    int n;
    logic [14:0] wa [16];
    for (int k = 1; k <= 6; k++) begin
      push(15'h0500 + 15'(k), 8'h40 + 8'(k), 1'b0);
      step();
    end
    bus.cpuWrReq = 1'b0;
    repeat (3) step();
    total++;
    if (bus.cpuWrFull !== 1'b1) begin
      bad++;
      $display("FAIL fp_prefull got=%b want=1", bus.cpuWrFull);
    end
    push(15'h0507, 8'h47, 1'b0);
    step();
    bus.cpuWrReq = 1'b0;
    total++;
    if (bus.cpuWrFull !== 1'b1 || bus.dropCount !== DROP2) begin
      bad++;
      $display("FAIL fp_accept got=%b/%0d want=1/%0d", bus.cpuWrFull, bus.dropCount, DROP2);
    end
    n = 0;
    for (int k = 0; k < 16; k++) wa[k] = '0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (bus.nvramWE === 1'b0) begin
        wa[n] = bus.vramAddr;
        n++;
      end
    end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL fp_count got=%0d want=5", n);
    end
    for (int j = 0; j < 5; j++) begin
      total++;
      if (wa[j] !== 15'h0503 + 15'(j)) begin
        bad++;
        $display("FAIL fp_order%0d got=%h want=%h", j, wa[j], 15'h0503 + 15'(j));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, nv;
    push(15'h0600, 8'h71, 1'b0);
    step();
    push(15'h0601, 8'h72, 1'b1);
    step();
    bus.cpuWrReq = 1'b0;
    step();
    total++;
    if (bus.nvramWE !== 1'b0) begin
      bad++;
      $display("FAIL mr_strobe got=%b want=0", bus.nvramWE);
    end
    #2;
    nReset = 1'b0;
    #1;
    total++;
    if ({bus.nvramWE, bus.nvramCE, bus.vramDataOe, bus.vramAddr} !== {4'b1110, 15'h0}) begin
      bad++;
      $display("FAIL mr_async got=%b/%h want=1110/0",
        {bus.nvramWE, bus.nvramCE, bus.vramDataOe}, bus.vramAddr);
    end
    total++;
    if ({bus.vidData, bus.dropCount} !== 16'd0) begin
      bad++;
      $display("FAIL mr_regs got=%h/%h want=0/0", bus.vidData, bus.dropCount);
    end
    #2;
    nReset = 1'b1;
    n = 0; nv = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus.nvramWE === 1'b0) n++;
      if (bus.vidValid === 1'b1) nv++;
    end
    total++;
    if (n != 0 || nv != 2 || bus.cpuWrFull !== 1'b0) begin
      bad++;
      $display("FAIL mr_after got=we%0d/rd%0d/full%b want=we0/rd2/full0",
        n, nv, bus.cpuWrFull);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_single_write();
    test_deferred();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
